// File: rtl/overture_pkg.sv
// Shared types and constants for the overture sequencer.
// Holds the FSM state enum, instruction-class codes, write-source codes
// and the special register indices used by the decoder and the sequencer.
package overture_pkg;

    localparam int unsigned PC_W    = 8;
    localparam int unsigned INSTR_W = 8;
    localparam int unsigned REG_W   = 3;
    localparam int unsigned WSRC_W  = 2;
    localparam int unsigned CLS_W   = 2;
    localparam int unsigned RET_W   = 16;

    typedef enum logic [2:0] {
        FETCH,
        LOAD,
        EXEC,
        WAIT_IO,
        HALT
    } state_t;

    // Instruction class, taken from ir[7:6]
    localparam logic [CLS_W-1:0] IMM  = 2'd0;
    localparam logic [CLS_W-1:0] CALC = 2'd1;
    localparam logic [CLS_W-1:0] COPY = 2'd2;
    localparam logic [CLS_W-1:0] COND = 2'd3;

    // Register-file write source select
    localparam logic [WSRC_W-1:0] WSRC_IMM = 2'd0;
    localparam logic [WSRC_W-1:0] WSRC_ALU = 2'd1;
    localparam logic [WSRC_W-1:0] WSRC_REG = 2'd2;
    localparam logic [WSRC_W-1:0] WSRC_IN  = 2'd3;

    // Fixed register indices
    localparam logic [REG_W-1:0] R0_IDX   = 3'd0;
    localparam logic [REG_W-1:0] R3_IDX   = 3'd3;
    localparam logic [REG_W-1:0] IO_IDX   = 3'd6;
    localparam logic [REG_W-1:0] HALT_IDX = 3'd7;

endpackage

// File: rtl/overture_seq_if.sv
// Bus bundle between the overture sequencer and its environment
// (instruction memory, register file, condition unit, I/O ports).
// master: the sequencer; slave: the surrounding datapath.
interface overture_seq_if;
    import overture_pkg::*;

    logic                run;
    logic [PC_W-1:0]     imem_addr;
    logic                imem_re;
    logic [INSTR_W-1:0]  imem_data;
    logic [PC_W-1:0]     jump_target;
    logic                cond_true;
    logic [INSTR_W-1:0]  ir;
    logic                rf_we;
    logic [REG_W-1:0]    rf_waddr;
    logic [REG_W-1:0]    rf_raddr;
    logic [WSRC_W-1:0]   wsrc;
    logic                in_valid;
    logic                in_ready;
    logic                out_valid;
    logic                out_ready;
    logic                halted;
    logic [RET_W-1:0]    retired;

    modport master (
        input  run, imem_data, jump_target, cond_true, in_valid, out_ready,
        output imem_addr, imem_re, ir, rf_we, rf_waddr, rf_raddr, wsrc,
               in_ready, out_valid, halted, retired
    );

    modport slave (
        output run, imem_data, jump_target, cond_true, in_valid, out_ready,
        input  imem_addr, imem_re, ir, rf_we, rf_waddr, rf_raddr, wsrc,
               in_ready, out_valid, halted, retired
    );

endinterface

// File: rtl/overture_decode.sv
// Combinational instruction decoder.
// Ports: ir (in, instruction) -> cls (class), src/dst (copy registers),
//        need_in/need_out (COPY touches the I/O port), is_halt (COPY names R7).
module overture_decode
    import overture_pkg::*;
(
    input  logic [INSTR_W-1:0] ir,
    output logic [CLS_W-1:0]   cls,
    output logic [REG_W-1:0]   src,
    output logic [REG_W-1:0]   dst,
    output logic               need_in,
    output logic               need_out,
    output logic               is_halt
);

    logic is_copy;

    assign cls     = ir[7:6];
    assign src     = ir[5:3];
    assign dst     = ir[2:0];
    assign is_copy = (cls == COPY);

    // Halt takes priority over any I/O side effect of the same COPY
    assign is_halt  = is_copy && ((src == HALT_IDX) || (dst == HALT_IDX));
    assign need_in  = is_copy && !is_halt && (src == IO_IDX);
    assign need_out = is_copy && !is_halt && (dst == IO_IDX);

endmodule

// File: rtl/overture_seq.sv
// Overture instruction sequencer: fetch / load / execute control with
// blocking I/O copies and a sticky halt.
// Ports: clk, rst (async, active-high), bus (overture_seq_if.master):
//        instruction-memory fetch, register-file write control, I/O
//        handshakes, halted flag and retired-instruction counter.
module overture_seq
    import overture_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst,
    overture_seq_if.master       bus
);

    state_t              state;
    logic [PC_W-1:0]     pc;
    logic [INSTR_W-1:0]  ir_q;
    logic                halted_q;
    logic [RET_W-1:0]    retired_q;

    logic [CLS_W-1:0]    cls;
    logic [REG_W-1:0]    src;
    logic [REG_W-1:0]    dst;
    logic                need_in;
    logic                need_out;
    logic                is_halt;
    logic                io_done;

    logic                imem_re;
    logic                rf_we;
    logic [REG_W-1:0]    rf_waddr;
    logic [WSRC_W-1:0]   wsrc;
    logic                in_ready;
    logic                out_valid;

    overture_decode u_decode (
        .ir       (ir_q),
        .cls      (cls),
        .src      (src),
        .dst      (dst),
        .need_in  (need_in),
        .need_out (need_out),
        .is_halt  (is_halt)
    );

    // Both sides of an I/O copy must be ready in the same cycle
    assign io_done = (!need_in || bus.in_valid) && (!need_out || bus.out_ready);

    // Control outputs decoded from state and ir; rst masks the fetch strobe
    always_comb begin
        imem_re   = 1'b0;
        rf_we     = 1'b0;
        rf_waddr  = R0_IDX;
        wsrc      = WSRC_IMM;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            FETCH: imem_re = bus.run && !rst;
            EXEC, WAIT_IO: begin
                case (cls)
                    IMM: begin
                        rf_we    = 1'b1;
                        rf_waddr = R0_IDX;
                        wsrc     = WSRC_IMM;
                    end
                    CALC: begin
                        rf_we    = 1'b1;
                        rf_waddr = R3_IDX;
                        wsrc     = WSRC_ALU;
                    end
                    COPY: begin
                        if (!is_halt) begin
                            rf_waddr  = dst;
                            wsrc      = need_in ? WSRC_IN : WSRC_REG;
                            in_ready  = need_in;
                            out_valid = need_out;
                            rf_we     = !need_out && io_done;
                        end
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // State, pc, ir and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            ir_q      <= '0;
            halted_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (bus.run) state <= LOAD;
                end
                LOAD: begin
                    ir_q  <= bus.imem_data;
                    state <= EXEC;
                end
                EXEC, WAIT_IO: begin
                    if (is_halt) begin
                        halted_q <= 1'b1;
                        state    <= HALT;
                    end else if (cls == COND || io_done) begin
                        if (cls == COND && bus.cond_true) pc <= bus.jump_target;
                        else                              pc <= pc + 8'd1;
                        if (retired_q != '1) retired_q <= retired_q + 16'd1;
                        state <= FETCH;
                    end else begin
                        state <= WAIT_IO;
                    end
                end
                HALT:    state <= HALT;
                default: state <= FETCH;
            endcase
        end
    end

    assign bus.imem_addr = pc;
    assign bus.imem_re   = imem_re;
    assign bus.ir        = ir_q;
    assign bus.rf_we     = rf_we;
    assign bus.rf_waddr  = rf_waddr;
    assign bus.rf_raddr  = src;
    assign bus.wsrc      = wsrc;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.halted    = halted_q;
    assign bus.retired   = retired_q;

endmodule

// File: tb/tb_overture_seq.sv
// Self-checking bench for overture_seq: instruction-table sweep with a
// register-write scoreboard, plus hand sequences for run gating, I/O waits,
// reset during WAIT_IO and halt.
module tb_overture_seq;

    typedef struct packed {
        logic [2:0] waddr;
        logic [1:0] wsrc;
        logic [2:0] raddr;
    } wr_t;

    typedef struct {
        logic [7:0] instr;
        logic       cond;
        logic [7:0] jt;
        logic       iv;
        logic       orr;
        logic       we;
        logic [2:0] waddr;
        logic [1:0] wsrc;
        logic [7:0] next_pc;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    int         n_tests = 0;
    int         n_fail  = 0;
    wr_t        sb[$];
    wr_t        mon_got;
    wr_t        mon_exp;
    logic [7:0] mem [256];
    vec_t       vt [13];
    logic [7:0] exp_pc;

    overture_seq_if bus();

    overture_seq #(.RESET_PC(8'h00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Instruction memory: data appears the cycle after the fetch strobe
    always @(posedge clk) begin
        if (bus.imem_re === 1'b1) bus.imem_data <= mem[bus.imem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write scoreboard: every rf_we pulse must match the oldest expected write
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.rf_we === 1'b1) begin
            mon_got = '{waddr: bus.rf_waddr, wsrc: bus.wsrc, raddr: bus.rf_raddr};
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got waddr=%0d wsrc=%0d, none expected",
                         bus.rf_waddr, bus.wsrc);
            end else begin
                mon_exp = sb.pop_front();
                chk("write_fields", 32'(mon_got), 32'(mon_exp));
            end
        end
    end

    function automatic vec_t mk(input logic [7:0] instr, input logic cond, input logic [7:0] jt,
                                input logic iv, input logic orr, input logic we,
                                input logic [2:0] waddr, input logic [1:0] wsrc,
                                input logic [7:0] next_pc);
        vec_t v;
        v.instr = instr; v.cond = cond; v.jt = jt; v.iv = iv; v.orr = orr;
        v.we = we; v.waddr = waddr; v.wsrc = wsrc; v.next_pc = next_pc;
        return v;
    endfunction

    // Called at a negedge in FETCH with imem_re high; returns at the next fetch
    task automatic run_vec(input vec_t v, input logic [7:0] pc_now);
        int cyc;
        wr_t w;
        cyc = 0;
        chk("fetch_addr", 32'(bus.imem_addr), 32'(pc_now));
        mem[pc_now]     = v.instr;
        bus.cond_true   = v.cond;
        bus.jump_target = v.jt;
        bus.in_valid    = v.iv;
        bus.out_ready   = v.orr;
        if (v.we) begin
            w = '{waddr: v.waddr, wsrc: v.wsrc, raddr: v.instr[5:3]};
            sb.push_back(w);
        end
        do begin
            @(negedge clk);
            cyc++;
        end while (bus.imem_re !== 1'b1 && cyc < 20);
        chk("instr_cycles", 32'(cyc), 32'd3);
        chk("next_addr", 32'(bus.imem_addr), 32'(v.next_pc));
    endtask

    initial begin
        int cnt;
        int early;
        wr_t w;

        vt[0]  = mk(8'h05, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 2'd0, 8'h01);
        vt[1]  = mk(8'h83, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 2'd2, 8'h02);
        vt[2]  = mk(8'h45, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 2'd1, 8'h03);
        vt[3]  = mk(8'hAA, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd2, 2'd2, 8'h04);
        vt[4]  = mk(8'hC0, 1'b0, 8'h40, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 8'h05);
        vt[5]  = mk(8'hC0, 1'b1, 8'h40, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 8'h40);
        vt[6]  = mk(8'hC7, 1'b1, 8'h40, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 8'h40);
        vt[7]  = mk(8'hC1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 8'hFF);
        vt[8]  = mk(8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 2'd0, 8'h00);
        vt[9]  = mk(8'h8D, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd5, 2'd2, 8'h01);
        vt[10] = mk(8'hB6, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 8'h02);
        vt[11] = mk(8'hB1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd1, 2'd3, 8'h03);
        vt[12] = mk(8'h96, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 8'h04);

        // Reset state, with run high to show the fetch strobe is masked
        rst = 1'b1;
        bus.run = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.cond_true = 1'b0;
        bus.jump_target = 8'h00;
        @(negedge clk);
        chk("rst_imem_re", 32'(bus.imem_re), 32'd0);
        chk("rst_pc", 32'(bus.imem_addr), 32'h00);
        chk("rst_ir", 32'(bus.ir), 32'h00);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        chk("rst_retired", 32'(bus.retired), 32'd0);
        chk("rst_rf_we", 32'(bus.rf_we), 32'd0);

        // run low after reset: no fetch
        bus.run = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.imem_re === 1'b1) cnt++;
        end
        chk("idle_fetches", 32'(cnt), 32'd0);
        @(posedge clk); #1 bus.run = 1'b1;
        @(negedge clk);
        chk("first_fetch", 32'(bus.imem_re), 32'd1);

        // Instruction table
        exp_pc = 8'h00;
        for (int i = 0; i < 13; i++) begin
            run_vec(vt[i], exp_pc);
            exp_pc = vt[i].next_pc;
            if (i == 1) chk("retired_after_2", 32'(bus.retired), 32'd2);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;

        // run falls during LOAD: instruction finishes, next fetch waits
        mem[exp_pc] = 8'h45;
        w = '{waddr: 3'd3, wsrc: 2'd1, raddr: 3'd0};
        sb.push_back(w);
        @(posedge clk); #1 bus.run = 1'b0;
        repeat (3) @(negedge clk);
        chk("runlow_no_fetch", 32'(bus.imem_re), 32'd0);
        chk("runlow_pc", 32'(bus.imem_addr), 32'h05);
        @(negedge clk);
        chk("runlow_hold", 32'(bus.imem_re), 32'd0);
        @(posedge clk); #1 bus.run = 1'b1;
        @(negedge clk);
        chk("run_resume", 32'(bus.imem_re), 32'd1);

        // COPY in->r0 with in_valid low for 4 cycles
        mem[8'h05] = 8'hB0;
        w = '{waddr: 3'd0, wsrc: 2'd3, raddr: 3'd6};
        sb.push_back(w);
        @(negedge clk);
        chk("in_ready_load", 32'(bus.in_ready), 32'd0);
        cnt = 0;
        early = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) cnt++;
            if (bus.rf_we !== 1'b0) early++;
        end
        @(posedge clk); #1 bus.in_valid = 1'b1;
        @(negedge clk);
        if (bus.in_ready === 1'b1) cnt++;
        chk("io_write_strobe", 32'(bus.rf_we), 32'd1);
        @(posedge clk); #1 bus.in_valid = 1'b0;
        @(negedge clk);
        chk("in_ready_cycles", 32'(cnt), 32'd5);
        chk("no_early_write", 32'(early), 32'd0);
        chk("in_ready_drop", 32'(bus.in_ready), 32'd0);
        chk("io_next_addr", 32'(bus.imem_addr), 32'h06);

        // COPY r0->out stalled, then reset between clock edges
        mem[8'h06] = 8'h86;
        @(negedge clk);
        @(negedge clk);
        chk("out_valid_exec", 32'(bus.out_valid), 32'd1);
        @(negedge clk);
        chk("out_valid_wait", 32'(bus.out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_out_valid", 32'(bus.out_valid), 32'd0);
        chk("async_imem_re", 32'(bus.imem_re), 32'd0);
        chk("async_pc", 32'(bus.imem_addr), 32'h00);
        chk("async_retired", 32'(bus.retired), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_fetch", 32'(bus.imem_re), 32'd1);

        // Halt on COPY to R7, left only by reset
        run_vec(mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 2'd0, 8'h01), 8'h00);
        mem[8'h01] = 8'hBF;
        cnt = 0;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            if (bus.imem_re === 1'b1) cnt++;
        end
        chk("halt_fetches", 32'(cnt), 32'd0);
        chk("halted", 32'(bus.halted), 32'd1);
        chk("halt_pc", 32'(bus.imem_addr), 32'h01);
        chk("halt_retired", 32'(bus.retired), 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        #1;
        chk("unhalt", 32'(bus.halted), 32'd0);
        chk("unhalt_pc", 32'(bus.imem_addr), 32'h00);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("unhalt_fetch", 32'(bus.imem_re), 32'd1);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
